stream_demux_n: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer and the successor to the team's 4-way combinational demux. Each beat arrives on a valid/ready input and is routed to one of N output channels. Routing is either by explicit select (ROUTE mode) or by rotating pointer (round-robin mode). Every output channel has a one-entry output register, so downstream back-pressure on one channel never corrupts the others. Sits between a single producer and N independent consumers.

---
 rtl/stream_demux_n.sv | 111 +++++++++++
 tb/tb_stream_demux_n.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with select or round-robin routing.
// Each output channel has a one-entry register so stalls stay local to that channel.
module stream_demux_n #(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rr_mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic [SEL_W-1:0] rr_ptr,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned    NumSlots = 1 << SEL_W;
    localparam logic [SEL_W:0] NumCh    = (SEL_W + 1)'(N);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } ch_state_e;

    ch_state_e         state_q [N];
    ch_state_e         state_d [N];
    logic [N*W-1:0]    data_q, data_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0]    dest;
    logic                dest_ok;
    logic [NumSlots-1:0] open_ext;
    logic [N-1:0]        push_vec;
    logic                accept;

    assign dest    = rr_mode ? rr_ptr_q : sel;
    assign dest_ok = {1'b0, dest} < NumCh;

    // Out-of-range slots read as closed; they are only reachable when dest_ok is false.
    always_comb begin
        open_ext = '0;
        for (int unsigned k = 0; k < N; k++) begin
            open_ext[k] = (state_q[k] == StEmpty) | out_ready[k];
        end
    end

    assign in_ready = en & (dest_ok ? open_ext[dest] : 1'b1);
    assign accept   = in_valid & in_ready;

    always_comb begin
        push_vec = '0;
        for (int unsigned k = 0; k < N; k++) begin
            push_vec[k] = accept & dest_ok & (dest == SEL_W'(k));
        end
    end

    always_comb begin
        data_d = data_q;
        for (int unsigned k = 0; k < N; k++) begin
            state_d[k] = state_q[k];
            unique case (state_q[k])
                StEmpty: if (push_vec[k]) state_d[k] = StFull;
                StFull:  if (out_ready[k] && !push_vec[k]) state_d[k] = StEmpty;
            endcase
            if (push_vec[k]) data_d[k*W +: W] = in_data;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (accept && rr_mode) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(N - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
        if (accept && !rr_mode && !dest_ok && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++) state_q[k] <= StEmpty;
            data_q     <= '0;
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) state_q[k] <= state_d[k];
            data_q     <= data_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int unsigned k = 0; k < N; k++) out_valid[k] = (state_q[k] == StFull);
    end

    assign out_data = data_q;
    assign rr_ptr   = rr_ptr_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance for routing and round-robin,
// and a 3-channel instance for out-of-range drops.
module tb_stream_demux_n;

    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, en, rr_mode, in_valid;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     in_data;

    logic             in_ready;
    logic [3:0]       out_valid, out_ready;
    logic [4*W-1:0]   out_data;
    logic [SEL_W-1:0] rr_ptr;
    logic [CNT_W-1:0] drop_cnt;

    logic             in_ready3;
    logic [2:0]       out_valid3, out_ready3;
    logic [3*W-1:0]   out_data3;
    logic [SEL_W-1:0] rr_ptr3;
    logic [CNT_W-1:0] drop_cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux_n #(.W(W), .N(4), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
    );

    stream_demux_n #(.W(W), .N(3), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .rr_ptr(rr_ptr3), .drop_cnt(drop_cnt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rr_mode = 1'b0; sel = 2'd1; in_valid = 1'b1;
        in_data = 8'h55; out_ready = 4'b0000; out_ready3 = 3'b111;
        tick();
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data);
        end
        checks++;
        if (rr_ptr !== 2'd0 || drop_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_ptr_cnt got=%0d/%0d exp=0/0", rr_ptr, drop_cnt);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_no_write got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_route_sweep();
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        out_ready = 4'b1111; rr_mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = SEL_W'(i);
            in_data = 8'hA0 + 8'(i);
            exp_v = 4'b0001 << i;
            exp_d = 8'hA0 + 8'(i);
            tick();
            checks++;
            if (out_valid !== exp_v || out_data[i*W +: W] !== exp_d) begin
                failures++;
                $display("FAIL route_sweep_%0d got=%b/%h exp=%b/%h", i, out_valid,
                         out_data[i*W +: W], exp_v, exp_d);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            failures++; $display("FAIL route_drain got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 4'b1011; sel = 2'd2; in_data = 8'h11; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'h11) begin
            failures++; $display("FAIL bp_first_store got=%b/%h exp=0100/11",
                                 out_valid, out_data[2*W +: W]);
        end
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_second_ready got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'h11) begin
            failures++; $display("FAIL bp_hold got=%b/%h exp=0100/11",
                                 out_valid, out_data[2*W +: W]);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_reopen_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'h22) begin
            failures++; $display("FAIL bp_pop_push got=%b/%h exp=0100/22",
                                 out_valid, out_data[2*W +: W]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr_wrap();
        int ch;
        logic [3:0] exp_v;
        rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ch = i % 4;
            in_data = 8'hB0 + 8'(i);
            exp_v = 4'b0001 << ch;
            tick();
            checks++;
            if (out_valid !== exp_v || out_data[ch*W +: W] !== 8'hB0 + 8'(i)) begin
                failures++;
                $display("FAIL rr_beat_%0d got=%b/%h exp=%b/%h", i, out_valid,
                         out_data[ch*W +: W], exp_v, 8'hB0 + 8'(i));
            end
        end
        checks++;
        if (rr_ptr !== 2'd2) begin
            failures++; $display("FAIL rr_ptr_after_wrap got=%0d exp=2", rr_ptr);
        end
        // Fill channel 2 in ROUTE mode so the round-robin pointer lands on a full channel.
        rr_mode = 1'b0; sel = 2'd2; in_data = 8'hD0; out_ready = 4'b1011;
        tick();
        checks++;
        if (rr_ptr !== 2'd2 || out_data[2*W +: W] !== 8'hD0) begin
            failures++; $display("FAIL rr_route_hold got=%0d/%h exp=2/d0",
                                 rr_ptr, out_data[2*W +: W]);
        end
        rr_mode = 1'b1; in_data = 8'hE0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rr_stall_ready got=%b exp=0", in_ready);
        end
        tick();
        tick();
        tick();
        checks++;
        if (rr_ptr !== 2'd2 || out_data[2*W +: W] !== 8'hD0) begin
            failures++; $display("FAIL rr_stall_hold got=%0d/%h exp=2/d0",
                                 rr_ptr, out_data[2*W +: W]);
        end
        out_ready = 4'b1111;
        tick();
        checks++;
        if (rr_ptr !== 2'd3 || out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'hE0) begin
            failures++; $display("FAIL rr_release got=%0d/%b/%h exp=3/0100/e0",
                                 rr_ptr, out_valid, out_data[2*W +: W]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rr_mode = 1'b0; sel = 2'd3; in_data = 8'hFF; in_valid = 1'b1;
        out_ready = 4'b1111; out_ready3 = 3'b111;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin
            failures++; $display("FAIL drop_in_ready got=%b exp=1", in_ready3);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid3 !== 3'b000) begin
                failures++; $display("FAIL drop_no_write_%0d got=%b exp=000", i, out_valid3);
            end
        end
        checks++;
        if (drop_cnt3 !== 8'd3) begin
            failures++; $display("FAIL drop_cnt_3 got=%0d exp=3", drop_cnt3);
        end
        for (int i = 3; i < 260; i++) tick();
        checks++;
        if (drop_cnt3 !== 8'd255 || out_data3 !== 24'h0) begin
            failures++; $display("FAIL drop_saturate got=%0d/%h exp=255/000000",
                                 drop_cnt3, out_data3);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++; $display("FAIL drop_in_range_no_count got=%0d exp=0", drop_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_enable_reset();
        out_ready = 4'b0000; rr_mode = 1'b0; in_valid = 1'b1;
        sel = 2'd0; in_data = 8'h31;
        tick();
        sel = 2'd1; in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0011) begin
            failures++; $display("FAIL en_fill got=%b exp=0011", out_valid);
        end
        en = 1'b0; in_valid = 1'b1; sel = 2'd2; in_data = 8'h33;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL en_off_ready got=%b exp=0", in_ready);
        end
        out_ready = 4'b0001;
        tick();
        checks++;
        if (out_valid !== 4'b0010 || out_data[W +: W] !== 8'h32) begin
            failures++; $display("FAIL en_off_drain got=%b/%h exp=0010/32",
                                 out_valid, out_data[W +: W]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            failures++; $display("FAIL mid_reset got=%b/%h exp=0000/00000000",
                                 out_valid, out_data);
        end
        rst = 1'b0; en = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_route_sweep();
        test_back_pressure();
        test_rr_wrap();
        test_drop();
        test_enable_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
